// File: rtl/xor_compl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xor_compl_pkg
//  Description : Definitions shared by the XOR-complement blocks. Holds the
//                common data width, the word type and the recovery function
//                that inverts the upstream transform: d = (-q) ^ key.
//  Revision    : 1.0 - initial release
// ============================================================================
package xor_compl_pkg;

    localparam int WIDTH = 20;

    typedef logic [WIDTH-1:0] word_t;

    // Two's-complement negation of q, modulo 2^WIDTH, XORed with the key.
    function automatic word_t recover(input word_t q, input word_t key);
        return (~q + word_t'(1)) ^ key;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xor_compl_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : xor_compl_fifo
//  Description : Circular-buffer FIFO with a registered first-word-fall-
//                through head. The head register keeps its last value while
//                the FIFO is empty, so the reader qualifies it with valid.
//  Ports       : clk, rst (async, active-low)
//                push/wdata  - write one word (caller guarantees room)
//                pop         - remove the head word (caller guarantees valid)
//                rdata/valid - head word and its qualifier
//                count/full  - occupancy, registered
//  Revision    : 1.0 - initial release
// ============================================================================
module xor_compl_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic [CW-1:0]    count,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;

    logic [AW-1:0]    w_rd_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] w_head_nxt;

    always_comb begin
        w_rd_nxt = pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

        case ({push, pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase

        // The head register is preloaded with whatever entry will sit at the
        // read pointer after this edge. If that slot is the one being written
        // right now (FIFO empty, or one entry leaving while one arrives), the
        // memory does not hold it yet, so bypass the write data.
        if (w_count_nxt == '0) begin
            w_head_nxt = r_head;
        end else if (push && (w_rd_nxt == r_wr_ptr)) begin
            w_head_nxt = wdata;
        end else begin
            w_head_nxt = r_mem[w_rd_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
            r_head   <= w_head_nxt;
        end
    end

    // Storage needs no reset: nothing is read from it until it has been
    // written, because the head register and count are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    assign rdata = r_head;
    assign valid = (r_count != '0);
    assign count = r_count;
    assign full  = (r_count == C_DEPTH);

endmodule
`default_nettype wire

// File: rtl/xor_compl_rx_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : xor_compl_rx_buffer
//  Description : Receive side of the XOR-complement block. Captures each
//                upstream result pulse, recovers the operand d = (-q) ^ key,
//                and queues recovered words for a valid/ready consumer.
//                Words arriving while the queue is full and not draining are
//                dropped and flagged in a sticky overflow bit.
//  Ports       : clk, rst (async, active-low)
//                q_in/v_q/key  - upstream result, strobe and recovery key
//                d_out/v_d     - recovered head word and its valid
//                rdy_d         - consumer ready
//                count/full    - FIFO occupancy
//                ovf/clr_ovf   - sticky drop flag and its synchronous clear
//  Revision    : 1.0 - initial release
// ============================================================================
module xor_compl_rx_buffer
    import xor_compl_pkg::*;
#(
    parameter int WIDTH = xor_compl_pkg::WIDTH,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] q_in,
    input  logic             v_q,
    input  logic [WIDTH-1:0] key,
    output logic [WIDTH-1:0] d_out,
    output logic             v_d,
    input  logic             rdy_d,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             ovf,
    input  logic             clr_ovf
);

    logic [WIDTH-1:0] w_recovered;
    logic [WIDTH-1:0] r_s1_data;
    logic             r_s1_vld;
    logic             r_ovf;

    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    // Use the shared recovery function whenever the width matches the
    // package word type; other widths fall back to the same expression.
    if (WIDTH == xor_compl_pkg::WIDTH) begin : g_pkg_recover
        assign w_recovered = recover(q_in, key);
    end else begin : g_generic_recover
        assign w_recovered = (~q_in + WIDTH'(1)) ^ key;
    end

    // Stage S1: one-word capture register, never stalls upstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
        end else begin
            r_s1_vld <= v_q;
            if (v_q) begin
                r_s1_data <= w_recovered;
            end
        end
    end

    // A full FIFO still accepts the S1 word when the head leaves on the
    // same edge, so only a stalled full FIFO drops.
    assign w_pop  = v_d && rdy_d;
    assign w_push = r_s1_vld && (!full || w_pop);
    assign w_drop = r_s1_vld && full && !w_pop;

    // Set has priority over clear so a drop on the clearing edge is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;

    xor_compl_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (r_s1_data),
        .rdata (d_out),
        .valid (v_d),
        .count (count),
        .full  (full)
    );

endmodule
`default_nettype wire

// File: tb/tb_xor_compl_rx_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xor_compl_rx_buffer
//  Description : Self-checking bench for xor_compl_rx_buffer. Directed
//                scenarios with hand-computed values plus a queue-model
//                random stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_compl_rx_buffer;

    logic        clk;
    logic        rst;
    logic [19:0] q_in;
    logic        v_q;
    logic [19:0] key;
    logic [19:0] d_out;
    logic        v_d;
    logic        rdy_d;
    logic [2:0]  count;
    logic        full;
    logic        ovf;
    logic        clr_ovf;

    int n_tests;
    int n_fail;

    xor_compl_rx_buffer #(
        .WIDTH (20),
        .DEPTH (4),
        .CW    (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .q_in    (q_in),
        .v_q     (v_q),
        .key     (key),
        .d_out   (d_out),
        .v_d     (v_d),
        .rdy_d   (rdy_d),
        .count   (count),
        .full    (full),
        .ovf     (ovf),
        .clr_ovf (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; q_in = '0; v_q = 1'b0; key = '0; rdy_d = 1'b0; clr_ovf = 1'b0;
        tick();
        tick();
        n_tests++; if (d_out !== 20'h0) begin n_fail++; $display("FAIL reset_d_out: got %h need 00000", d_out); end
        n_tests++; if (v_d !== 1'b0)    begin n_fail++; $display("FAIL reset_v_d: got %b need 0", v_d); end
        n_tests++; if (count !== 3'd0)  begin n_fail++; $display("FAIL reset_count: got %0d need 0", count); end
        n_tests++; if (full !== 1'b0)   begin n_fail++; $display("FAIL reset_full: got %b need 0", full); end
        n_tests++; if (ovf !== 1'b0)    begin n_fail++; $display("FAIL reset_ovf: got %b need 0", ovf); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_word();
        rdy_d = 1'b1; key = 20'h0000F; q_in = 20'hFFFF6; v_q = 1'b1;
        tick();                                 // E0: captured in S1
        v_q = 1'b0;
        n_tests++; if (v_d !== 1'b0) begin n_fail++; $display("FAIL single_early_v_d: got %b need 0", v_d); end
        tick();                                 // E1: in FIFO
        n_tests++; if (v_d !== 1'b1)        begin n_fail++; $display("FAIL single_v_d: got %b need 1", v_d); end
        n_tests++; if (d_out !== 20'h00005) begin n_fail++; $display("FAIL single_d_out: got %h need 00005", d_out); end
        tick();                                 // E2: consumed
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_count: got %0d need 0", count); end
        n_tests++; if (v_d !== 1'b0)   begin n_fail++; $display("FAIL single_v_d_after: got %b need 0", v_d); end
    endtask

    task automatic send_check(input logic [19:0] q, input logic [19:0] k,
                              input logic [19:0] exp, input string name);
        rdy_d = 1'b1; q_in = q; key = k; v_q = 1'b1;
        tick();
        v_q = 1'b0;
        tick();
        n_tests++;
        if (v_d !== 1'b1 || d_out !== exp) begin
            n_fail++;
            $display("FAIL %s: got v_d=%b d_out=%h need v_d=1 d_out=%h", name, v_d, d_out, exp);
        end
        tick();
    endtask

    task automatic test_arith_edges();
        send_check(20'h00000, 20'hABCDE, 20'hABCDE, "arith_zero");
        send_check(20'h80000, 20'h00000, 20'h80000, "arith_msb");
        send_check(20'h00001, 20'h00000, 20'hFFFFF, "arith_one");
    endtask

    task automatic test_fill_overflow();
        logic [19:0] exp_w [4];
        exp_w[0] = 20'hFFFFF; exp_w[1] = 20'hFFFFE; exp_w[2] = 20'hFFFFD; exp_w[3] = 20'hFFFFC;
        rdy_d = 1'b0; key = '0;
        for (int i = 1; i <= 6; i++) begin
            q_in = 20'(i); v_q = 1'b1;
            tick();
            // The 5th word leaves S1 on the edge that captures the 6th.
            n_tests++;
            if (ovf !== (i >= 6)) begin
                n_fail++; $display("FAIL fill_ovf_step%0d: got %b need %b", i, ovf, (i >= 6));
            end
        end
        v_q = 1'b0;
        tick();
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d need 4", count); end
        n_tests++; if (full !== 1'b1)  begin n_fail++; $display("FAIL fill_full: got %b need 1", full); end
        n_tests++; if (ovf !== 1'b1)   begin n_fail++; $display("FAIL fill_ovf: got %b need 1", ovf); end
        rdy_d = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (v_d !== 1'b1 || d_out !== exp_w[k]) begin
                n_fail++;
                $display("FAIL drain_word%0d: got v_d=%b d_out=%h need v_d=1 d_out=%h", k, v_d, d_out, exp_w[k]);
            end
            tick();
        end
        n_tests++; if (v_d !== 1'b0 || count !== 3'd0) begin
            n_fail++; $display("FAIL drain_empty: got v_d=%b count=%0d need 0/0", v_d, count);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %b need 0", ovf); end
    endtask

    task automatic test_full_push_pop();
        logic [19:0] exp_w [4];
        exp_w[0] = 20'hFFFEF; exp_w[1] = 20'hFFFEE; exp_w[2] = 20'hFFFED; exp_w[3] = 20'hFFFEC;
        rdy_d = 1'b0; key = '0;
        for (int i = 0; i < 5; i++) begin
            q_in = 20'h00010 + 20'(i); v_q = 1'b1;
            tick();
        end
        v_q = 1'b0;
        // Four words queued, fifth (0x14) waiting in S1.
        n_tests++; if (count !== 3'd4 || d_out !== 20'hFFFF0) begin
            n_fail++; $display("FAIL fpp_pre: got count=%0d d_out=%h need 4/FFFF0", count, d_out);
        end
        rdy_d = 1'b1;
        tick();
        rdy_d = 1'b0;
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fpp_count: got %0d need 4", count); end
        n_tests++; if (ovf !== 1'b0)   begin n_fail++; $display("FAIL fpp_ovf: got %b need 0", ovf); end
        rdy_d = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (v_d !== 1'b1 || d_out !== exp_w[k]) begin
                n_fail++;
                $display("FAIL fpp_word%0d: got v_d=%b d_out=%h need v_d=1 d_out=%h", k, v_d, d_out, exp_w[k]);
            end
            tick();
        end
        n_tests++; if (v_d !== 1'b0) begin n_fail++; $display("FAIL fpp_empty: got v_d=%b need 0", v_d); end
    endtask

    task automatic test_random_stream();
        logic [19:0] mq [$];
        logic        m_s1v;
        logic [19:0] m_s1d;
        logic        m_ovf;
        logic        m_pop;
        logic        m_full;
        logic        vq;
        logic        rd;
        logic [19:0] qv;
        logic [19:0] kv;
        int          errs;
        m_s1v = 1'b0; m_s1d = '0; m_ovf = 1'b0; errs = 0;
        for (int i = 0; i < 200; i++) begin
            vq = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 2) == 0);
            qv = 20'($urandom);
            kv = 20'($urandom);
            q_in = qv; key = kv; v_q = vq; rdy_d = rd;
            m_pop  = (mq.size() != 0) && rd;
            m_full = (mq.size() == 4);
            if (m_pop) void'(mq.pop_front());
            if (m_s1v) begin
                if (!m_full || m_pop) mq.push_back(m_s1d);
                else m_ovf = 1'b1;
            end
            m_s1v = vq;
            m_s1d = (20'h00000 - qv) ^ kv;
            tick();
            n_tests++;
            if (v_d !== (mq.size() != 0) || int'(count) != mq.size() || ovf !== m_ovf ||
                (mq.size() != 0 && d_out !== mq[0])) begin
                n_fail++;
                if (errs < 5)
                    $display("FAIL rand_cycle%0d: got v_d=%b count=%0d ovf=%b d_out=%h need count=%0d ovf=%b head=%h",
                             i, v_d, count, ovf, d_out, mq.size(), m_ovf, (mq.size() != 0) ? mq[0] : 20'h0);
                errs++;
            end
        end
        v_q = 1'b0; rdy_d = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        n_tests++; if (v_d !== 1'b0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL rand_drain: got v_d=%b ovf=%b need 0/0", v_d, ovf);
        end
    endtask

    task automatic test_reset_mid();
        rdy_d = 1'b0; key = 20'h12345;
        for (int i = 0; i < 4; i++) begin
            q_in = 20'h00100 + 20'(i); v_q = 1'b1;
            tick();
        end
        v_q = 1'b0;
        n_tests++; if (count !== 3'd3 || v_d !== 1'b1) begin
            n_fail++; $display("FAIL rmid_pre: got count=%0d v_d=%b need 3/1", count, v_d);
        end
        #2;
        rst = 1'b0;
        #1;
        n_tests++; if (v_d !== 1'b0 || count !== 3'd0 || d_out !== 20'h0 || full !== 1'b0) begin
            n_fail++; $display("FAIL rmid_async: got v_d=%b count=%0d d_out=%h full=%b need 0/0/00000/0",
                               v_d, count, d_out, full);
        end
        tick();
        #3;
        rst = 1'b1;
        rdy_d = 1'b1;
        tick();
        tick();
        tick();
        n_tests++; if (v_d !== 1'b0 || count !== 3'd0 || d_out !== 20'h0) begin
            n_fail++; $display("FAIL rmid_stale: got v_d=%b count=%0d d_out=%h need 0/0/00000", v_d, count, d_out);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single_word();
        test_arith_edges();
        test_fill_overflow();
        test_full_push_pop();
        test_random_stream();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
